// File: rtl/arbitro_ruteo_n.sv
// ============================================================================
// Module  : arbitro_ruteo_n
// Brief   : Routes the main FIFO head word to one of N egress FIFOs by its top
//           destination bits, with back-pressure, channel drop and counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_ruteo_n #(
  parameter int DATA_SIZE    = 12,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_BITS      = 2,
  parameter int CNT_SIZE     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [DATA_SIZE-1:0]    fifo_data,
  input  logic [NUM_CHANNELS-1:0] fifo_almost_full,
  input  logic [NUM_CHANNELS-1:0] ch_enable,
  output logic                    pop,
  output logic [NUM_CHANNELS-1:0] push,
  output logic [DATA_SIZE-1:0]    data_out,
  input  logic                    req,
  input  logic [CH_BITS:0]        idx,
  output logic [CNT_SIZE-1:0]     cont,
  output logic                    cont_valid,
  output logic                    idle
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;

  localparam logic [CNT_SIZE-1:0] CNT_ONE  = {{(CNT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CH_BITS:0]    IDX_DROP = NUM_CHANNELS[CH_BITS:0];

  logic [1:0]              state_q, state_d;
  logic [NUM_CHANNELS-1:0] push_q, push_d;
  logic [DATA_SIZE-1:0]    data_q;
  logic [CNT_SIZE-1:0]     cnt_q [NUM_CHANNELS];
  logic [CNT_SIZE-1:0]     drop_cnt_q;
  logic [CNT_SIZE-1:0]     cont_q, cont_d;
  logic                    cont_valid_q;

  logic [CH_BITS-1:0] dest;
  logic               fwd;
  logic               drop;

  assign dest = fifo_data[DATA_SIZE-1 -: CH_BITS];
  // Reset gates both decisions so no word leaves the main FIFO during reset.
  assign fwd  = !reset && !fifo_empty && ch_enable[dest] && !fifo_almost_full[dest];
  assign drop = !reset && !fifo_empty && !ch_enable[dest];
  assign pop  = fwd || drop;

  always_comb begin
    push_d = '0;
    if (fwd) begin
      push_d[dest] = 1'b1;
    end
  end

  always_comb begin
    cont_d = '0;
    if (!idx[CH_BITS]) begin
      cont_d = cnt_q[idx[CH_BITS-1:0]];
    end else if (idx == IDX_DROP) begin
      cont_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q       <= '0;
      data_q       <= '0;
      drop_cnt_q   <= '0;
      cont_q       <= '0;
      cont_valid_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      push_q       <= push_d;
      cont_valid_q <= req;
      if (fwd) begin
        data_q <= fifo_data;
      end
      if (req) begin
        cont_q <= cont_d;
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_ONE;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (push_d[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A popped word is always in flight into ACTIVE, so an empty FIFO can go straight to IDLE.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      state_d = S_ACTIVE;
    end else if (!fifo_empty) begin
      state_d = S_STALL;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    idle = (state_q == S_IDLE);
  end

  assign push       = push_q;
  assign data_out   = data_q;
  assign cont       = cont_q;
  assign cont_valid = cont_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_ruteo_n.sv
// ============================================================================
// Module  : tb_arbitro_ruteo_n
// Brief   : Directed self-checking bench for arbitro_ruteo_n (N=4, 12-bit words).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_ruteo_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [11:0] fifo_data;
  logic [3:0]  fifo_almost_full;
  logic [3:0]  ch_enable;
  logic        pop;
  logic [3:0]  push;
  logic [11:0] data_out;
  logic        req;
  logic [2:0]  idx;
  logic [4:0]  cont;
  logic        cont_valid;
  logic        idle;

  int n_vec  = 0;
  int n_miss = 0;

  arbitro_ruteo_n #(
    .DATA_SIZE(12), .NUM_CHANNELS(4), .CH_BITS(2), .CNT_SIZE(5)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_almost_full(fifo_almost_full), .ch_enable(ch_enable), .pop(pop),
    .push(push), .data_out(data_out), .req(req), .idx(idx), .cont(cont),
    .cont_valid(cont_valid), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; registered outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] w, input logic exp_pop, input logic [3:0] exp_push);
    fifo_empty = 1'b0;
    fifo_data  = w;
    #1;
    chk("pop", {31'd0, pop}, {31'd0, exp_pop});
    cyc();
    chk("push", {28'd0, push}, {28'd0, exp_push});
    if (exp_push != 4'd0) chk("data_out", {20'd0, data_out}, {20'd0, w});
  endtask

  task automatic read_cnt(input logic [2:0] sel, input logic [4:0] exp);
    req = 1'b1;
    idx = sel;
    cyc();
    req = 1'b0;
    chk("cont_valid", {31'd0, cont_valid}, 32'd1);
    chk($sformatf("cont[%0d]", sel), {27'd0, cont}, {27'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; fifo_empty = 1'b1; fifo_data = '0; fifo_almost_full = '0;
    ch_enable = 4'hF; req = 1'b0; idx = '0;
    cyc();
    fifo_empty = 1'b0; fifo_data = 12'h010;
    #1;
    chk("pop_in_reset", {31'd0, pop}, 32'd0);
    cyc();
    fifo_empty = 1'b1;
    reset = 1'b0;
    chk("rst_push", {28'd0, push}, 32'd0);
    chk("rst_data", {20'd0, data_out}, 32'd0);
    chk("rst_cont", {27'd0, cont}, 32'd0);
    chk("rst_cvalid", {31'd0, cont_valid}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);

    // One word per channel on consecutive cycles
    send(12'h3FF, 1'b1, 4'b0001);
    send(12'h7FF, 1'b1, 4'b0010);
    send(12'hBFF, 1'b1, 4'b0100);
    send(12'hFFF, 1'b1, 4'b1000);
    fifo_empty = 1'b1;
    cyc();
    chk("push_off", {28'd0, push}, 32'd0);
    chk("data_hold", {20'd0, data_out}, 32'hFFF);
    for (int i = 0; i < 4; i++) read_cnt(i[2:0], 5'd1);
    read_cnt(3'd4, 5'd0);
    read_cnt(3'd7, 5'd0);
    cyc();
    chk("cvalid_off", {31'd0, cont_valid}, 32'd0);
    chk("cont_hold", {27'd0, cont}, 32'd0);
    chk("idle_empty", {31'd0, idle}, 32'd1);

    // Back-pressure on channel 1
    fifo_almost_full = 4'b0010;
    send(12'h410, 1'b0, 4'b0000);
    chk("stall_idle", {31'd0, idle}, 32'd0);
    send(12'h410, 1'b0, 4'b0000);
    fifo_almost_full = 4'b0000;
    send(12'h410, 1'b1, 4'b0010);
    fifo_empty = 1'b1;
    read_cnt(3'd1, 5'd2);

    // Disabled channel 1 drops, channel 0 still forwards
    ch_enable = 4'b1101;
    send(12'h410, 1'b1, 4'b0000);
    chk("drop_hold", {20'd0, data_out}, 32'h410);
    send(12'h010, 1'b1, 4'b0001);
    fifo_empty = 1'b1;
    read_cnt(3'd4, 5'd1);
    read_cnt(3'd0, 5'd2);

    // Counter wrap after a clean reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ch_enable = 4'hF;
    for (int i = 0; i < 33; i++) send(12'(i), 1'b1, 4'b0001);
    fifo_empty = 1'b1;
    read_cnt(3'd0, 5'd1);

    // Read and increment on the same edge returns the old value
    fifo_empty = 1'b0; fifo_data = 12'h005; req = 1'b1; idx = 3'd0;
    cyc();
    req = 1'b0; fifo_empty = 1'b1;
    chk("rd_inc_push", {28'd0, push}, 32'h1);
    chk("rd_inc_old", {27'd0, cont}, 32'd1);
    read_cnt(3'd0, 5'd2);

    // Drop counter saturation
    ch_enable = 4'b1110;
    for (int i = 0; i < 40; i++) send(12'h020, 1'b1, 4'b0000);
    fifo_empty = 1'b1;
    read_cnt(3'd4, 5'd31);
    read_cnt(3'd0, 5'd2);

    // Reset raised during a pop cycle
    ch_enable = 4'hF;
    send(12'h801, 1'b1, 4'b0100);
    fifo_empty = 1'b0; fifo_data = 12'h802; reset = 1'b1;
    #1;
    chk("pop_mid_rst", {31'd0, pop}, 32'd0);
    cyc();
    reset = 1'b0; fifo_empty = 1'b1;
    chk("mid_rst_push", {28'd0, push}, 32'd0);
    chk("mid_rst_data", {20'd0, data_out}, 32'd0);
    chk("mid_rst_idle", {31'd0, idle}, 32'd1);
    for (int i = 0; i < 5; i++) read_cnt(i[2:0], 5'd0);
    send(12'h803, 1'b1, 4'b0100);
    fifo_empty = 1'b1;
    read_cnt(3'd2, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbitro_ruteo_n.md
# arbitro_ruteo_n

Parametrised routing arbiter between the main ingress FIFO and N egress FIFOs. It pops the head word of the main FIFO and pushes it into the egress FIFO selected by the word's top destination bits. It applies back-pressure from each egress FIFO's almost-full flag and discards words addressed to disabled channels. It also keeps per-channel push counters and a drop counter, which can be read back through a request/valid port.

## Interface
- DATA_SIZE, 12, word width; destination field is the top CH_BITS bits.
- NUM_CHANNELS, 4, egress FIFO count; power of two, 2..16.
- CH_BITS, 2, log2(NUM_CHANNELS).
- CNT_SIZE, 5, width of each push counter and of the drop counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  main FIFO empty.
- fifo_data  in  DATA_SIZE  main FIFO head word (first-word-fall-through, valid while !fifo_empty).
- fifo_almost_full  in  NUM_CHANNELS  per-egress almost-full flags.
- ch_enable  in  NUM_CHANNELS  per-channel enable; 0 = drop words for that channel.
- pop  out  1  main FIFO pop (combinational).
- push  out  NUM_CHANNELS  one-hot egress push (registered).
- data_out  out  DATA_SIZE  word to egress FIFOs (registered).
- req  in  1  counter read request.
- idx  in  CH_BITS+1  counter select: 0..NUM_CHANNELS-1 = push counter; NUM_CHANNELS = drop counter; others read 0.
- cont  out  CNT_SIZE  counter readback.
- cont_valid  out  1  cont valid strobe.
- idle  out  1  FSM in IDLE.

## Operation
- dest = fifo_data[DATA_SIZE-1 -: CH_BITS].
- fwd = !reset && !fifo_empty && ch_enable[dest] && !fifo_almost_full[dest].
- drop = !reset && !fifo_empty && !ch_enable[dest].
- pop = fwd || drop.
- A blocked word (enabled, almost full) stalls the FIFO. Head-of-line blocking is strict: no bypass to other channels.
- On fwd: next edge, push[dest]=1, data_out=fifo_data, push count[dest]+1.
- Otherwise on that edge: push=0 and data_out holds its last value.
- On drop: no push; drop counter +1.
- Push counters wrap modulo 2^CNT_SIZE. The drop counter saturates at 2^CNT_SIZE-1.
- Readback: req at edge t gives cont_valid=1 and cont=selected counter at t+1. The value returned is the pre-edge value, excluding any increment at that same edge. Without req, cont_valid=0 and cont holds its value.
- FSM states:
  - IDLE: fifo_empty and no push in flight.
  - ACTIVE: a word was popped in the last cycle or a pop is possible.
  - STALL: !fifo_empty && !pop.
- FSM transitions, evaluated each edge from the current inputs:
  - pop → ACTIVE.
  - !fifo_empty && !pop → STALL.
  - fifo_empty → IDLE, via ACTIVE if a push is in flight.
- Reset:
  - state=IDLE; push=0, data_out=0, all counters=0, cont=0, cont_valid=0, idle=1.
  - pop is forced 0 while reset is high, including mid-stream.
  - The word that was due to push on the reset edge is lost.
  - Main FIFO contents are not this block's concern.

## Timing
- pop: combinational, same cycle as the head word and flags.
- Latency: pop in cycle t → push/data_out in cycle t+1. Throughput 1 word/cycle.
- The egress almost-full threshold must leave ≥1 free entry, because one word can still be in flight after almost_full rises.
- fifo_almost_full and ch_enable changes take effect on the same-cycle pop decision.
- Simultaneous readback and increment on one counter returns the old value; the new value is visible one cycle later.

## Test plan
- Reset, then stream 0x3FF, 0x7FF, 0xBFF, 0xFFF (N=4):
  - push0..push3 one-hot on consecutive cycles, each 1 cycle after its pop.
  - data_out matches each word.
  - Reading idx 0..3 returns cont=1 each.
- Hold fifo_almost_full[1]=1 with head 0x410:
  - pop=0, state STALL, no push.
  - Release the flag: pop in the same cycle, push1 next cycle with data_out=0x410.
- ch_enable=4'b1101 with words 0x410, 0x010:
  - First word popped, no push, drop counter reads 1.
  - Second word pushes push0.
- 33 words to channel 0: count0 reads 1 (wrap). 40 drops on a disabled channel: drop counter reads 31 (saturation).
- Reset raised mid-stream during a pop cycle:
  - pop=0 during reset, no push after the edge.
  - All counters read 0, idle=1.
  - The stream resumes correctly once reset is deasserted.
